shift_reg_univ: RTL and testbench

Parametrised universal register, the successor to the single-bit D flip-flop. It is a WIDTH-bit register with hold, parallel load, and single-step left/right shift under an enable. It also runs an autonomous burst-shift engine that shifts N positions and then pulses done. It sits wherever the design needs a loadable or serialising register, for example as a serial/parallel converter front-end.

---
 rtl/shift_reg_pkg.sv | 26 ++
 rtl/shift_reg_next.sv | 25 ++
 rtl/shift_reg_univ.sv | 90 +++++++++
 tb/tb_shift_reg_univ.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the universal shift register: operation and
// state encodings, burst-direction constants and the burst-length clamp.
package shift_reg_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHL  = 2'b01,
      MODE_SHR  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Burst lengths beyond the register width saturate to the width.
   function automatic int unsigned clamp_shift(input int unsigned n,
                                               input int unsigned width);
      return (n > width) ? width : n;
   endfunction

endpackage

// File: rtl/shift_reg_next.sv
// Combinational next-value mux for the register: hold, shift left/right with
// a serial input bit, or parallel load.
module shift_reg_next
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  mode_e            op,
   output logic [WIDTH-1:0] q_next
);

   always_comb begin
      q_next = q;
      case (op)
         MODE_SHL:  q_next = {q[WIDTH-2:0], sin};
         MODE_SHR:  q_next = {sin, q[WIDTH-1:1]};
         MODE_LOAD: q_next = d;
         default:   q_next = q;
      endcase
   end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal register with manual hold/load/shift and an autonomous burst-shift
// engine that performs N shifts and then pulses done for one cycle.
module shift_reg_univ
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             start,
   input  logic [CNT_W-1:0] n_shift,
   input  logic             dir,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             dir_r, dir_nxt;
   logic             done_nxt;
   logic [CNT_W-1:0] cnt_clamped;
   mode_e            op;
   logic [WIDTH-1:0] q_next;

   assign cnt_clamped = CNT_W'(clamp_shift(int'(n_shift), WIDTH));

   shift_reg_next #(.WIDTH(WIDTH)) u_next (
      .q      (q),
      .d      (d),
      .sin    (sin),
      .op     (op),
      .q_next (q_next)
   );

   // start outranks a manual operation in IDLE; SHIFT ignores all controls.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dir_nxt   = dir_r;
      done_nxt  = 1'b0;
      op        = MODE_HOLD;
      case (state)
         ST_IDLE: begin
            if (start) begin
               cnt_nxt = cnt_clamped;
               dir_nxt = dir;
               if (cnt_clamped == '0) done_nxt = 1'b1;
               else                   state_nxt = ST_SHIFT;
            end else if (en) begin
               op = mode_e'(mode);
            end
         end
         ST_SHIFT: begin
            op      = (dir_r == DIR_RIGHT) ? MODE_SHR : MODE_SHL;
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         dir_r <= DIR_LEFT;
         done  <= 1'b0;
         q     <= RST_VAL;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         dir_r <= dir_nxt;
         done  <= done_nxt;
         q     <= q_next;
      end
   end

   assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: an integer-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_shift_reg_univ;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] d = 8'h00;
   logic       sin = 1'b0;
   logic       start = 1'b0;
   logic [3:0] n_shift = 4'd0;
   logic       dir = 1'b0;
   logic [7:0] q;
   logic       busy;
   logic       done;

   int checks = 0;
   int failures = 0;

   shift_reg_univ dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .d       (d),
      .sin     (sin),
      .start   (start),
      .n_shift (n_shift),
      .dir     (dir),
      .q       (q),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: remaining burst shifts as an integer, q as an integer.
   int m_q = 0;
   int m_rem = 0;
   int m_dir = 0;
   int m_done = 0;
   int n_eff;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q = 0; m_rem = 0; m_dir = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (m_rem > 0) begin
            if (m_dir == 0) m_q = ((m_q * 2) + sin) % 256;
            else            m_q = (m_q / 2) + (sin ? 128 : 0);
            m_rem = m_rem - 1;
            if (m_rem == 0) m_done = 1;
         end else if (start) begin
            n_eff = (n_shift > 8) ? 8 : int'(n_shift);
            m_dir = dir;
            if (n_eff == 0) m_done = 1;
            else            m_rem = n_eff;
         end else if (en) begin
            case (mode)
               2'b01: m_q = ((m_q * 2) + sin) % 256;
               2'b10: m_q = (m_q / 2) + (sin ? 128 : 0);
               2'b11: m_q = d;
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      check("model_q", q, m_q);
      check("model_busy", busy, (m_rem > 0) ? 1 : 0);
      check("model_done", done, m_done);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   int nb;
   int seen_done;

   initial begin
      // reset state
      tick(); tick();
      check("rst_q", q, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      tick();

      // load, hold, disabled
      en = 1; mode = 2'b11; d = 8'hA5; tick();
      check("load_a5", q, 8'hA5);
      mode = 2'b00; tick(); tick(); tick();
      check("hold_a5", q, 8'hA5);
      en = 0; mode = 2'b11; d = 8'hFF; tick();
      check("en_off_a5", q, 8'hA5);

      // manual shifts
      en = 1; mode = 2'b01; sin = 1; tick();
      check("shl_4b", q, 8'h4B);
      mode = 2'b10; sin = 0; tick();
      check("shr_25", q, 8'h25);

      // burst left by 3, then back-to-back burst right by 1
      mode = 2'b11; d = 8'h81; tick();
      en = 0; start = 1; n_shift = 4'd3; dir = 0; sin = 0; tick();
      start = 0;
      nb = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) break;
         if (busy) nb++;
         tick();
      end
      check("burst3_busy_cycles", nb, 3);
      check("burst3_q", q, 8'h08);
      check("burst3_done", done, 1);
      check("burst3_busy_off", busy, 0);
      start = 1; n_shift = 4'd1; dir = 1; sin = 1; tick();
      start = 0; tick();
      check("burst1_q", q, 8'h84);
      check("burst1_done", done, 1);

      // zero-length and saturated bursts
      start = 1; n_shift = 4'd0; tick();
      start = 0;
      check("burst0_done", done, 1);
      check("burst0_busy", busy, 0);
      check("burst0_q", q, 8'h84);
      tick();
      check("burst0_done_once", done, 0);
      start = 1; n_shift = 4'd15; dir = 0; sin = 1; tick();
      start = 0;
      nb = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) break;
         if (busy) nb++;
         tick();
      end
      check("burst15_busy_cycles", nb, 8);
      check("burst15_q", q, 8'hFF);

      // controls ignored while shifting
      tick();
      en = 1; mode = 2'b11; d = 8'h3C; tick();
      en = 0; start = 1; n_shift = 4'd4; dir = 1; sin = 1; tick();
      en = 1; mode = 2'b11; d = 8'h00; start = 1; n_shift = 4'd2; dir = 0;
      tick(); tick(); tick(); tick();
      check("ignore_q", q, 8'hF3);
      check("ignore_done", done, 1);
      en = 0; start = 0; tick();

      // reset mid-burst aborts without a done pulse
      start = 1; n_shift = 4'd8; dir = 0; sin = 0; tick();
      start = 0; tick();
      #2 rst_n = 1'b0;
      #1;
      check("abort_q", q, 8'h00);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      tick();
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) seen_done = 1;
      end
      check("abort_no_done", seen_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
